// File: rtl/trace_event_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : trace_event_arbiter_pkg
// Description : Shared types and constants for the trace event arbiter:
//               the event record, the r3 register index and the width of
//               the per-port drop counters.
// Revision    : 1.0 - initial release
// ============================================================================
package trace_event_arbiter_pkg;

  localparam int ID_W       = 16;
  localparam int ARG_W      = 32;
  localparam int REG_IDX_W  = 5;
  localparam int DROP_CNT_W = 8;

  // Register whose latest written value becomes the event argument
  localparam logic [REG_IDX_W-1:0]  R3_IDX       = 5'd3;
  localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = '1;

  typedef struct packed {
    logic [ID_W-1:0]  id;
    logic [ARG_W-1:0] arg;
  } trace_event_t;

endpackage
`default_nettype wire

// File: rtl/trace_event_fifo.sv
`default_nettype none
// ============================================================================
// Module      : trace_event_fifo
// Description : Small synchronous FIFO of trace events with a first-word
//               fall-through head. Pushes into a full FIFO are ignored even
//               if the same cycle pops, so fullness is judged pre-pop.
// Revision    : 1.0 - initial release
// ============================================================================
module trace_event_fifo
  import trace_event_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  trace_event_t push_data,
  input  logic         pop,
  output trace_event_t head,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  trace_event_t   mem [FIFO_DEPTH];
  logic [AW:0]    wr_ptr;
  logic [AW:0]    rd_ptr;

  // Extra pointer bit distinguishes full from empty when the indices match
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  // Storage write; contents need no reset because the pointers gate them
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

  // Pointer update; full is sampled before this cycle's pop takes effect
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop && !empty) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/trace_event_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : trace_event_arbiter
// Description : Collects l.nop trace events from NUM_PORTS cores, tags each
//               with the core's current r3 value, buffers them per core and
//               merges them round-robin into one ready/valid output stream.
//               Events hitting a full buffer are counted, not stalled.
// Revision    : 1.0 - initial release
// ============================================================================
module trace_event_arbiter
  import trace_event_arbiter_pkg::*;
#(
  parameter int NUM_PORTS  = 4,
  parameter int FIFO_DEPTH = 4,
  localparam int PORT_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_PORTS-1:0]           wb_valid,
  input  logic [NUM_PORTS-1:0]           wb_we,
  input  logic [REG_IDX_W*NUM_PORTS-1:0] wb_addr,
  input  logic [ARG_W*NUM_PORTS-1:0]     wb_data,
  input  logic [NUM_PORTS-1:0]           nop_valid,
  input  logic [ID_W*NUM_PORTS-1:0]      nop_id,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [PORT_W-1:0]              out_port,
  output logic [ID_W-1:0]                out_id,
  output logic [ARG_W-1:0]               out_arg,
  output logic [DROP_CNT_W*NUM_PORTS-1:0] drop_count
);

  localparam logic [PORT_W:0]   NUM_PORTS_W = (PORT_W+1)'(NUM_PORTS);
  localparam logic [PORT_W-1:0] LAST_PORT   = PORT_W'(NUM_PORTS - 1);

  trace_event_t         head [NUM_PORTS];
  logic [NUM_PORTS-1:0] fifo_full;
  logic [NUM_PORTS-1:0] fifo_empty;
  logic [NUM_PORTS-1:0] fifo_pop;

  logic [PORT_W-1:0]    rr_ptr;
  logic [PORT_W-1:0]    grant;
  logic [PORT_W-1:0]    next_ptr;
  logic [PORT_W:0]      cand;
  logic                 found;
  logic                 load;
  trace_event_t         winner;

  // The output register may take a new event when empty or being drained
  assign load   = ~out_valid | out_ready;
  assign winner = head[grant];

  genvar p;
  generate
    for (p = 0; p < NUM_PORTS; p++) begin : g_port
      logic                  r3_wr;
      logic [ARG_W-1:0]      shadow;
      logic [DROP_CNT_W-1:0] drop_cnt;
      logic                  push;
      logic                  drop;
      trace_event_t          push_data;

      assign r3_wr = wb_valid[p] & wb_we[p] &
                     (wb_addr[REG_IDX_W*p +: REG_IDX_W] == R3_IDX);

      // A same-cycle r3 write wins over the stored shadow
      assign push_data.id  = nop_id[ID_W*p +: ID_W];
      assign push_data.arg = r3_wr ? wb_data[ARG_W*p +: ARG_W] : shadow;

      assign push = nop_valid[p] & ~fifo_full[p];
      assign drop = nop_valid[p] &  fifo_full[p];

      assign fifo_pop[p] = load & found & (grant == PORT_W'(p));
      assign drop_count[DROP_CNT_W*p +: DROP_CNT_W] = drop_cnt;

      // Track the most recent value written to r3 on this core
      always_ff @(posedge clk) begin
        if (rst) begin
          shadow <= '0;
        end else if (r3_wr) begin
          shadow <= wb_data[ARG_W*p +: ARG_W];
        end
      end

      // Count events lost to a full buffer, sticking at the maximum
      always_ff @(posedge clk) begin
        if (rst) begin
          drop_cnt <= '0;
        end else if (drop && (drop_cnt != DROP_CNT_MAX)) begin
          drop_cnt <= drop_cnt + 1'b1;
        end
      end

      trace_event_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
      ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (fifo_pop[p]),
        .head      (head[p]),
        .full      (fifo_full[p]),
        .empty     (fifo_empty[p])
      );
    end
  endgenerate

  // Round-robin search starting at rr_ptr for the first non-empty FIFO
  always_comb begin
    found = 1'b0;
    grant = '0;
    cand  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      cand = {1'b0, rr_ptr} + (PORT_W+1)'(i);
      if (cand >= NUM_PORTS_W) begin
        cand = cand - NUM_PORTS_W;
      end
      if (!found && !fifo_empty[cand[PORT_W-1:0]]) begin
        found = 1'b1;
        grant = cand[PORT_W-1:0];
      end
    end
  end

  // Search restarts just past the port that was served
  always_comb begin
    next_ptr = (grant == LAST_PORT) ? '0 : grant + 1'b1;
  end

  // Output register and round-robin pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_port  <= '0;
      out_id    <= '0;
      out_arg   <= '0;
      rr_ptr    <= '0;
    end else if (load) begin
      if (found) begin
        out_valid <= 1'b1;
        out_port  <= grant;
        out_id    <= winner.id;
        out_arg   <= winner.arg;
        rr_ptr    <= next_ptr;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire
